fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 45 ++++
 rtl/fetch_stage_if.sv | 37 +++
 rtl/fetch_decode.sv | 59 +++++
 rtl/fetch_stage.sv | 63 ++++++
 tb/tb_fetch_stage.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage constants, stat codes and the D register bundle.
package fetch_stage_pkg;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [3:0] S_AOK = 4'd1;
   localparam logic [3:0] S_HLT = 4'd2;
   localparam logic [3:0] S_ADR = 4'd3;
   localparam logic [3:0] S_INS = 4'd4;

   localparam logic [3:0]  R_NONE   = 4'hF;
   localparam logic [63:0] IMEM_MAX = 64'd1023;

   typedef struct packed {
      logic [3:0]  stat;
      logic [3:0]  icode;
      logic [3:0]  ifun;
      logic [3:0]  rA;
      logic [3:0]  rB;
      logic [63:0] valC;
      logic [63:0] valP;
   } d_reg_t;

   localparam d_reg_t D_BUBBLE = '{
      stat:  S_AOK,
      icode: I_NOP,
      ifun:  4'h0,
      rA:    R_NONE,
      rB:    R_NONE,
      valC:  64'd0,
      valP:  64'd0
   };

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: PC feedback, instruction bytes, control and D outputs.
interface fetch_stage_if;
   logic [63:0]        F_predPC;
   logic [79:0]        current_instruction;
   logic [3:0]         M_icode;
   logic [3:0]         W_icode;
   logic               M_Cnd;
   logic signed [63:0] M_valA;
   logic signed [63:0] W_valM;
   logic               F_stall;
   logic               D_stall;
   logic               D_bubble;
   logic [63:0]        f_predPC;
   logic [3:0]         D_stat;
   logic [3:0]         D_icode;
   logic [3:0]         D_ifun;
   logic [3:0]         D_rA;
   logic [3:0]         D_rB;
   logic [63:0]        D_valC;
   logic [63:0]        D_valP;

   modport master (
      output F_predPC, current_instruction,
      output M_icode, W_icode, M_Cnd, M_valA, W_valM,
      output F_stall, D_stall, D_bubble,
      input  f_predPC, D_stat, D_icode, D_ifun,
      input  D_rA, D_rB, D_valC, D_valP
   );

   modport slave (
      input  F_predPC, current_instruction,
      input  M_icode, W_icode, M_Cnd, M_valA, W_valM,
      input  F_stall, D_stall, D_bubble,
      output f_predPC, D_stat, D_icode, D_ifun,
      output D_rA, D_rB, D_valC, D_valP
   );
endinterface

// File: rtl/fetch_decode.sv
// Combinational instruction split, length decode, valC/valP and status.
module fetch_decode
   import fetch_stage_pkg::*;
(
   input  logic [63:0] pc_i,
   input  logic [79:0] instr_i,
   output d_reg_t      dec_o
);

   logic [7:0]  byte_w [10];
   logic        need_regids;
   logic        need_valC;
   logic        valid;
   logic [3:0]  icode;
   logic [63:0] valC;

   always_comb begin
      for (int i = 0; i < 10; i++)
         byte_w[i] = instr_i[79-8*i -: 8];
   end

   assign icode = byte_w[0][7:4];
   assign valid = (icode <= I_POPQ);

   assign need_regids = icode inside {
      I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
      I_OPQ, I_PUSHQ, I_POPQ};

   assign need_valC = icode inside {
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_JXX, I_CALL};

   // Little-endian constant; starts one byte later when regids present.
   always_comb begin
      valC = 64'd0;
      if (need_valC) begin
         for (int k = 0; k < 8; k++)
            valC[8*k +: 8] = need_regids ? byte_w[k+2] : byte_w[k+1];
      end
   end

   always_comb begin
      dec_o       = D_BUBBLE;
      dec_o.icode = icode;
      dec_o.ifun  = byte_w[0][3:0];
      dec_o.rA    = need_regids ? byte_w[1][7:4] : R_NONE;
      dec_o.rB    = need_regids ? byte_w[1][3:0] : R_NONE;
      dec_o.valC  = valC;
      dec_o.valP  = pc_i + 64'd1
                  + {63'd0, need_regids}
                  + (need_valC ? 64'd8 : 64'd0);
      unique case (1'b1)
         (pc_i > IMEM_MAX):  dec_o.stat = S_ADR;
         (!valid):           dec_o.stat = S_INS;
         (icode == I_HALT):  dec_o.stat = S_HLT;
         default:            dec_o.stat = S_AOK;
      endcase
   end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC select, decode, next-PC prediction and the D register.
module fetch_stage
   import fetch_stage_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   fetch_stage_if.slave bus
);

   logic [63:0] f_pc;
   d_reg_t      dec;
   d_reg_t      d_d;
   d_reg_t      d_q;

   // A not-taken jump in M outranks a returning RET in W.
   always_comb begin
      if (bus.M_icode == I_JXX && !bus.M_Cnd)
         f_pc = bus.M_valA;
      else if (bus.W_icode == I_RET)
         f_pc = bus.W_valM;
      else
         f_pc = bus.F_predPC;
   end

   fetch_decode u_decode (
      .pc_i    (f_pc),
      .instr_i (bus.current_instruction),
      .dec_o   (dec)
   );

   always_comb begin
      if (bus.F_stall)
         bus.f_predPC = bus.F_predPC;
      else if (dec.icode == I_JXX || dec.icode == I_CALL)
         bus.f_predPC = dec.valC;
      else
         bus.f_predPC = dec.valP;
   end

   always_comb begin
      d_d = d_q;
      if (bus.D_bubble)
         d_d = D_BUBBLE;
      else if (!bus.D_stall)
         d_d = dec;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         d_q <= D_BUBBLE;
      else
         d_q <= d_d;
   end

   assign bus.D_stat  = d_q.stat;
   assign bus.D_icode = d_q.icode;
   assign bus.D_ifun  = d_q.ifun;
   assign bus.D_rA    = d_q.rA;
   assign bus.D_rB    = d_q.rB;
   assign bus.D_valC  = d_q.valC;
   assign bus.D_valP  = d_q.valP;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed-vector bench for fetch_stage.
module tb_fetch_stage;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   fetch_stage_if bus ();

   fetch_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(
      input string       tag,
      input logic [63:0] got,
      input logic [63:0] exp
   );
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic drive(
      input logic [63:0] pc,
      input logic [79:0] ins,
      input logic [3:0]  mi,
      input logic        mc,
      input logic [63:0] mva,
      input logic [3:0]  wi,
      input logic [63:0] wvm,
      input logic        fs,
      input logic        ds,
      input logic        db
   );
      @(negedge clk);
      bus.F_predPC            = pc;
      bus.current_instruction = ins;
      bus.M_icode             = mi;
      bus.M_Cnd               = mc;
      bus.M_valA              = mva;
      bus.W_icode             = wi;
      bus.W_valM              = wvm;
      bus.F_stall             = fs;
      bus.D_stall             = ds;
      bus.D_bubble            = db;
      #1;
   endtask

   task automatic edge_wait();
      @(posedge clk);
      #1;
   endtask

   task automatic plain(input logic [63:0] pc,
                        input logic [79:0] ins);
      drive(pc, ins, 4'h0, 1'b1, 64'd0, 4'h0, 64'd0,
            1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      plain(64'd0, 80'h1010_0000_0000_0000_0000);
      check("rst_icode", 64'(bus.D_icode), 64'h1);
      check("rst_rA",    64'(bus.D_rA),    64'hF);
      check("rst_stat",  64'(bus.D_stat),  64'h1);
      check("rst_valP",  bus.D_valP,       64'h0);
      rst = 1'b0;

      plain(64'd0, 80'h1010_0000_0000_0000_0000);
      check("nop_pred", bus.f_predPC, 64'd1);
      edge_wait();
      check("nop_icode", 64'(bus.D_icode), 64'h1);
      check("nop_ifun",  64'(bus.D_ifun),  64'h0);
      check("nop_rB",    64'(bus.D_rB),    64'hF);
      check("nop_valP",  bus.D_valP,       64'd1);
      check("nop_stat",  64'(bus.D_stat),  64'h1);

      plain(64'd2, 80'h6003_0000_0000_0000_0000);
      edge_wait();
      check("opq_icode", 64'(bus.D_icode), 64'h6);
      check("opq_rA",    64'(bus.D_rA),    64'h0);
      check("opq_rB",    64'(bus.D_rB),    64'h3);
      check("opq_valP",  bus.D_valP,       64'd4);

      plain(64'd6, 80'h4003_0000_0000_0000_000F);
      edge_wait();
      check("rm_icode", 64'(bus.D_icode), 64'h4);
      check("rm_valC",  bus.D_valC, 64'h0F00_0000_0000_0000);
      check("rm_valP",  bus.D_valP, 64'd16);

      plain(64'd18, 80'h0000_0000_0000_0000_0000);
      edge_wait();
      check("hlt_icode", 64'(bus.D_icode), 64'h0);
      check("hlt_stat",  64'(bus.D_stat),  64'h2);
      check("hlt_valP",  bus.D_valP,       64'd19);

      plain(64'h50, 80'hC000_0000_0000_0000_0000);
      edge_wait();
      check("ins_stat", 64'(bus.D_stat), 64'h4);

      drive(64'h0, 80'h1000_0000_0000_0000_0000,
            4'h7, 1'b0, 64'h20, 4'h9, 64'h40,
            1'b0, 1'b0, 1'b0);
      edge_wait();
      check("misp_valP", bus.D_valP, 64'h21);

      drive(64'h0, 80'h1000_0000_0000_0000_0000,
            4'h1, 1'b0, 64'h20, 4'h9, 64'h40,
            1'b0, 1'b0, 1'b0);
      edge_wait();
      check("ret_valP", bus.D_valP, 64'h41);

      plain(64'h30, 80'h7000_0100_0000_0000_0000);
      check("jxx_pred", bus.f_predPC, 64'h100);
      edge_wait();
      check("jxx_valC", bus.D_valC, 64'h100);
      check("jxx_valP", bus.D_valP, 64'h39);

      drive(64'h0, 80'h6003_0000_0000_0000_0000,
            4'h0, 1'b1, 64'd0, 4'h0, 64'd0,
            1'b0, 1'b1, 1'b0);
      edge_wait();
      check("stall_icode", 64'(bus.D_icode), 64'h7);
      check("stall_valC",  bus.D_valC,       64'h100);

      drive(64'h0, 80'h6003_0000_0000_0000_0000,
            4'h0, 1'b1, 64'd0, 4'h0, 64'd0,
            1'b0, 1'b1, 1'b1);
      edge_wait();
      check("bub_icode", 64'(bus.D_icode), 64'h1);
      check("bub_valP",  bus.D_valP,       64'h0);
      check("bub_rA",    64'(bus.D_rA),    64'hF);

      drive(64'h55, 80'h7000_0100_0000_0000_0000,
            4'h0, 1'b1, 64'd0, 4'h0, 64'd0,
            1'b1, 1'b0, 1'b0);
      check("fstall_pred", bus.f_predPC, 64'h55);

      plain(64'd1024, 80'h1000_0000_0000_0000_0000);
      edge_wait();
      check("adr_stat", 64'(bus.D_stat), 64'h3);

      plain(64'd2, 80'h6003_0000_0000_0000_0000);
      edge_wait();
      check("pre_icode", 64'(bus.D_icode), 64'h6);
      #2;
      rst = 1'b1;
      #1;
      check("arst_icode", 64'(bus.D_icode), 64'h1);
      check("arst_rA",    64'(bus.D_rA),    64'hF);
      edge_wait();
      check("hold_icode", 64'(bus.D_icode), 64'h1);
      plain(64'd2, 80'h6003_0000_0000_0000_0000);
      rst = 1'b0;
      edge_wait();
      check("rel_icode", 64'(bus.D_icode), 64'h6);
      check("rel_valP",  bus.D_valP,       64'd4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
